// File: rtl/pc_call_stack.sv
// pc_call_stack
//   Program counter with a circular hardware return-address stack. It sits
//   between the decode control strobes and the ROM address bus.
//   One action is taken per cycle, in this order of priority:
//   reset > ret > call > load > inc > hold.
// Ports
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high; out=RESET_VECTOR, stack emptied, flags cleared
//   in     : jump/call target address
//   load   : out <= in
//   inc    : out <= out + STEP (wraps silently)
//   call   : push out+STEP, out <= in
//   ret    : out <= top of stack, pop
//   out    : current PC (registered)
//   depth  : number of valid stack entries
//   ovf    : sticky, call issued while the stack was full
//   unf    : sticky, ret issued while the stack was empty
module pc_call_stack #(
    parameter int WIDTH        = 16,
    parameter int DEPTH        = 8,
    parameter int STEP         = 1,
    parameter int RESET_VECTOR = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in,
    input  logic                       load,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       ovf,
    output logic                       unf
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] stack [DEPTH];
    // top points at the next free slot. When the stack is full it wraps
    // onto the oldest entry, so a push there overwrites the oldest entry.
    logic [PW-1:0]    top;
    logic [PW-1:0]    top_inc;
    logic [PW-1:0]    top_dec;
    logic [WIDTH-1:0] ra;

    always_comb begin
        ra      = out + WIDTH'(STEP);
        top_inc = (top == PW'(DEPTH-1)) ? '0 : top + PW'(1);
        top_dec = (top == '0) ? PW'(DEPTH-1) : top - PW'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out   <= WIDTH'(RESET_VECTOR);
            depth <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
            top   <= '0;
        end else if (ret) begin
            // An empty pop holds out so no stale entry ever reaches the bus.
            if (depth != '0) begin
                out   <= stack[top_dec];
                top   <= top_dec;
                depth <= depth - DW'(1);
            end else begin
                unf <= 1'b1;
            end
        end else if (call) begin
            stack[top] <= ra;
            top        <= top_inc;
            out        <= in;
            if (depth == DW'(DEPTH)) begin
                ovf <= 1'b1;
            end else begin
                depth <= depth + DW'(1);
            end
        end else if (load) begin
            out <= in;
        end else if (inc) begin
            out <= ra;
        end
    end

endmodule
